ula_sequencial: RTL and testbench

ULA_SEQUENCIAL -- requirements
Module: ula_sequencial

---
 rtl/ula_pkg.sv | 40 ++++
 rtl/ula_comb.sv | 45 ++++
 rtl/ula_sequencial.sv | 105 ++++++++++
 tb/tb_ula_sequencial.sv | 139 +++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared ALU control codes, FSM state type and the one-bit shift step
// used by the serial shifter.
package ula_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SUB2 = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    function automatic logic [31:0] shift_one(input logic [3:0] op, input logic [31:0] w);
        logic [31:0] r;
        case (op)
            ALU_SLL: r = {w[30:0], 1'b0};
            ALU_SRL: r = {1'b0, w[31:1]};
            ALU_SRA: r = {w[31], w[31:1]};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ula_comb.sv
// Single-cycle ALU operations. Shift codes pass B through, which is the
// correct result for a zero shift amount; longer shifts run serially.
module ula_comb
    import ula_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        ovf,
    output logic        ill
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        y   = 32'd0;
        ovf = 1'b0;
        ill = 1'b0;
        case (op)
            ALU_ADD: begin
                y   = sum;
                ovf = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB, ALU_SUB2: begin
                y   = diff;
                ovf = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'd0, a < b};
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_LUI:  y = {b[15:0], 16'h0000};
            ALU_SLL, ALU_SRL, ALU_SRA: y = b;
            ALU_NOR:  y = ~(a | b);
            default:  ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/ula_sequencial.sv
// Sequential ALU: single-cycle ops finish on the accepting edge, shifts
// by k>0 move one bit per clock through a serial shifter.
module ula_sequencial
    import ula_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  ALUControl,
    input  logic        shamt,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  sa,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        illegal,
    output logic        busy,
    output logic        done
);

    state_t      state_reg;
    logic [3:0]  op_reg;
    logic [31:0] work_reg;
    logic [4:0]  cnt_reg;

    logic [4:0]  k_next;
    logic [31:0] comb_y;
    logic        comb_ovf;
    logic        comb_ill;
    logic [31:0] work_shifted;

    assign k_next       = shamt ? sa : A[4:0];
    assign work_shifted = shift_one(op_reg, work_reg);

    ula_comb u_comb (
        .op  (ALUControl),
        .a   (A),
        .b   (B),
        .y   (comb_y),
        .ovf (comb_ovf),
        .ill (comb_ill)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            op_reg    <= ALU_ADD;
            work_reg  <= 32'd0;
            cnt_reg   <= 5'd0;
            result    <= 32'd0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_reg   <= ALUControl;
                        work_reg <= B;
                        cnt_reg  <= k_next;
                        busy     <= 1'b1;
                        if (is_shift_op(ALUControl) && (k_next != 5'd0)) begin
                            state_reg <= ST_SHIFT;
                        end else begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                            result    <= comb_y;
                            zero      <= (comb_y == 32'd0);
                            overflow  <= comb_ovf;
                            illegal   <= comb_ill;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_reg <= work_shifted;
                    cnt_reg  <= cnt_reg - 5'd1;
                    // Last bit moves on this edge: publish the shifted word now.
                    if (cnt_reg == 5'd1) begin
                        state_reg <= ST_DONE;
                        done      <= 1'b1;
                        result    <= work_shifted;
                        zero      <= (work_shifted == 32'd0);
                        overflow  <= 1'b0;
                        illegal   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_sequencial.sv
// Directed-vector bench for ula_sequencial with hand-computed expectations.
module tb_ula_sequencial;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  ALUControl = 4'd0;
    logic        shamt = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [4:0]  sa = 5'd0;
    logic [31:0] result;
    logic        zero, overflow, illegal, busy, done;

    int checks = 0;
    int errors = 0;

    ula_sequencial dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .ALUControl (ALUControl),
        .shamt      (shamt),
        .A          (A),
        .B          (B),
        .sa         (sa),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .illegal    (illegal),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction: accept, scramble inputs, wait for done, check outputs,
    // then confirm return to IDLE. poke pulses start mid-SHIFT and in DONE.
    task automatic do_op(input string name, input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] s, input logic sh,
                         input int exp_lat, input logic [31:0] exp_res,
                         input logic exp_ovf, input logic exp_ill, input bit poke);
        int cyc;
        int busyc;
        logic [31:0] held;
        @(negedge clock);
        ALUControl = code; A = a; B = b; sa = s; shamt = sh; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        ALUControl = 4'hF; A = ~a; B = ~b; sa = ~s; shamt = ~sh;
        cyc = 1;
        busyc = busy ? 1 : 0;
        while (!done && cyc < 64) begin
            start = (poke && cyc == 2);
            @(posedge clock); #1;
            cyc++;
            if (busy) busyc++;
        end
        start = 1'b0;
        check({name, ".lat"}, cyc, exp_lat);
        check({name, ".busy"}, busyc, exp_lat);
        check({name, ".result"}, result, exp_res);
        check({name, ".zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
        check({name, ".ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
        check({name, ".illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
        held = result;
        if (poke) start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check({name, ".idle"}, {30'd0, busy, done}, 32'd0);
        @(posedge clock); #1;
        check({name, ".hold"}, result, held);
        $display("op %s code=%b lat=%0d result=%h zero=%b ovf=%b ill=%b",
                 name, code, cyc, result, zero, overflow, illegal);
    endtask

    initial begin
        int dones;
        #12;
        check("rst.result", result, 32'd0);
        check("rst.flags", {28'd0, zero, overflow, illegal, busy}, 32'h8);
        check("rst.done", {31'd0, done}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        do_op("add",  4'b0000, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b0, 1, 32'h80000000, 1'b1, 1'b0, 1'b1);
        do_op("sub",  4'b0001, 32'd5, 32'd5, 5'd0, 1'b0, 1, 32'h0, 1'b0, 1'b0, 1'b0);
        do_op("sub2", 4'b0010, 32'h80000000, 32'd1, 5'd0, 1'b0, 1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
        do_op("slt",  4'b0011, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0, 1, 32'd1, 1'b0, 1'b0, 1'b0);
        do_op("sltu", 4'b0100, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0, 1, 32'd0, 1'b0, 1'b0, 1'b0);
        do_op("and",  4'b0101, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 1'b0, 1, 32'h00F000F0, 1'b0, 1'b0, 1'b0);
        do_op("or",   4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 1'b0, 1, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
        do_op("xor",  4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 1'b0, 1, 32'hFF00FF00, 1'b0, 1'b0, 1'b0);
        do_op("nor",  4'b1111, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 1'b0, 1, 32'h000F000F, 1'b0, 1'b0, 1'b0);
        do_op("sra",  4'b1011, 32'd0, 32'h80000000, 5'd4, 1'b1, 5, 32'hF8000000, 1'b0, 1'b0, 1'b1);
        do_op("srl",  4'b1010, 32'd0, 32'h80000000, 5'd4, 1'b1, 5, 32'h08000000, 1'b0, 1'b0, 1'b1);
        do_op("sllv", 4'b1001, 32'd31, 32'd1, 5'd3, 1'b0, 32, 32'h80000000, 1'b0, 1'b0, 1'b0);
        do_op("sllv0", 4'b1001, 32'd32, 32'h12345678, 5'd7, 1'b0, 1, 32'h12345678, 1'b0, 1'b0, 1'b0);
        do_op("ill",  4'b1100, 32'd1, 32'd2, 5'd0, 1'b0, 1, 32'd0, 1'b0, 1'b1, 1'b0);
        do_op("lui",  4'b1000, 32'd0, 32'h0000ABCD, 5'd0, 1'b0, 1, 32'hABCD0000, 1'b0, 1'b0, 1'b0);
        do_op("ill2", 4'b1110, 32'd1, 32'd2, 5'd0, 1'b0, 1, 32'd0, 1'b0, 1'b1, 1'b0);
        do_op("lui2", 4'b1000, 32'd0, 32'h00001234, 5'd0, 1'b0, 1, 32'h12340000, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a 20-bit srl.
        @(negedge clock);
        ALUControl = 4'b1010; A = 32'd0; B = 32'hFFFFFFFF; sa = 5'd20; shamt = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("midrst.busy_before", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst.result", result, 32'd0);
        check("midrst.flags", {27'd0, zero, overflow, illegal, busy, done}, 32'h10);
        dones = 0;
        repeat (25) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        check("midrst.nodone", dones, 0);
        @(negedge clock);
        reset_n = 1'b1;
        $display("op midrst reset applied during srl, done pulses=%0d", dones);
        do_op("postrst", 4'b0000, 32'd3, 32'd4, 5'd0, 1'b0, 1, 32'd7, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
